// File: rtl/sram_req_ctrl.sv
// sram_req_ctrl: request-side controller for a single-port SRAM macro wrapper
// (active-low CEB/WEB, 1-cycle synchronous read). Turns a valid/ready request
// stream into SRAM pin activity, captures read data into a small response FIFO
// and uses credit-based backpressure so read data is never dropped. All
// accesses are blocked while scan is enabled (macro clock gated in scan).
//
// Ports:
//   clk_i, rst_i        clock (shared with SRAM wrapper), async active-high reset
//   scan_en_i           1 = block all SRAM accesses
//   req_valid_i/req_ready_o/req_we_i/req_addr_i/req_wdata_i   request stream
//   rsp_valid_o/rsp_ready_i/rsp_rdata_o                       read response stream
//   sram_ceb_o/sram_web_o/sram_a_o/sram_d_o/sram_q_i          SRAM macro pins
module sram_req_ctrl #(
   parameter int unsigned NUM_WORD  = 2048,
   parameter int unsigned NUM_BIT   = 32,
   parameter int unsigned ADDR_W    = $clog2(NUM_WORD),
   parameter int unsigned RSP_DEPTH = 3
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               scan_en_i,
   input  logic               req_valid_i,
   output logic               req_ready_o,
   input  logic               req_we_i,
   input  logic [ADDR_W-1:0]  req_addr_i,
   input  logic [NUM_BIT-1:0] req_wdata_i,
   output logic               rsp_valid_o,
   input  logic               rsp_ready_i,
   output logic [NUM_BIT-1:0] rsp_rdata_o,
   output logic               sram_ceb_o,
   output logic               sram_web_o,
   output logic [ADDR_W-1:0]  sram_a_o,
   output logic [NUM_BIT-1:0] sram_d_o,
   input  logic [NUM_BIT-1:0] sram_q_i
);

   localparam int unsigned PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(RSP_DEPTH + 1);
   localparam logic [PTR_W-1:0] PTR_LAST   = PTR_W'(RSP_DEPTH - 1);
   localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(RSP_DEPTH);
   localparam logic [CNT_W:0]   CREDIT_MAX = (CNT_W+1)'(RSP_DEPTH);

   logic [NUM_BIT-1:0] fifo_mem [RSP_DEPTH];
   logic [PTR_W-1:0]   wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
   logic [CNT_W-1:0]   count, count_nxt;
   logic               rd_inflight;
   logic               rsp_valid_q;
   logic [NUM_BIT-1:0] rsp_rdata_q, rsp_rdata_nxt;
   logic               fire, push, pop;

   // Circular pointer increment; depth need not be a power of two
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
   endfunction

   // Credit check counts the read already at the macro, so every accepted read
   // has a FIFO slot reserved; only registered state feeds ready
   always_comb begin
      req_ready_o = ~scan_en_i &
                    (req_we_i | (({1'b0, count} + (CNT_W+1)'(rd_inflight)) < CREDIT_MAX));
      fire        = req_valid_i & req_ready_o;
   end

   // SRAM pins are driven in the fire cycle; A/D are don't-care when idle
   always_comb begin
      sram_ceb_o = ~fire;
      sram_web_o = ~(fire & req_we_i);
      sram_a_o   = req_addr_i;
      sram_d_o   = req_wdata_i;
   end

   assign push = rd_inflight;
   assign pop  = rsp_valid_q & rsp_ready_i;

   // FIFO next state; the output head register is preloaded from the slot that
   // will be at rd_ptr next cycle, bypassing sram_q_i when that slot is the one
   // being pushed (FIFO empty after this cycle's pop)
   always_comb begin
      count_nxt     = count;
      rd_ptr_nxt    = rd_ptr;
      wr_ptr_nxt    = wr_ptr;
      rsp_rdata_nxt = rsp_rdata_q;
      case ({push, pop})
         2'b10:   count_nxt = count + CNT_W'(1);
         2'b01:   count_nxt = count - CNT_W'(1);
         default: count_nxt = count;
      endcase
      if (pop)  rd_ptr_nxt = ptr_inc(rd_ptr);
      if (push) wr_ptr_nxt = ptr_inc(wr_ptr);
      if (count_nxt != '0) begin
         if (push && (wr_ptr == rd_ptr_nxt)) rsp_rdata_nxt = sram_q_i;
         else                                rsp_rdata_nxt = fifo_mem[rd_ptr_nxt];
      end
   end

   // Storage array; contents are meaningless while count says empty
   always_ff @(posedge clk_i) begin
      if (push) fifo_mem[wr_ptr] <= sram_q_i;
   end

   // Control state; reset drops any read in flight at the macro
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         count       <= '0;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         rd_inflight <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         count       <= count_nxt;
         rd_ptr      <= rd_ptr_nxt;
         wr_ptr      <= wr_ptr_nxt;
         rd_inflight <= fire & ~req_we_i;
         rsp_valid_q <= (count_nxt != '0);
         rsp_rdata_q <= rsp_rdata_nxt;
      end
   end

   assign rsp_valid_o = rsp_valid_q;
   assign rsp_rdata_o = rsp_rdata_q;

   // The credit rule must make a push into a full FIFO impossible
   a_no_push_full: assert property (@(posedge clk_i) disable iff (rst_i)
                                    !(push && (count == CNT_FULL)));

endmodule

// File: tb/tb_sram_req_ctrl.sv
// Directed bench for sram_req_ctrl with a behavioural SRAM macro model.
// Unwritten SRAM words read back as their own address.
module tb_sram_req_ctrl;

   localparam int unsigned NUM_WORD = 2048;
   localparam int unsigned NUM_BIT  = 32;
   localparam int unsigned ADDR_W   = 11;

   logic               clk_i = 1'b0;
   logic               rst_i;
   logic               scan_en_i;
   logic               req_valid_i;
   logic               req_ready_o;
   logic               req_we_i;
   logic [ADDR_W-1:0]  req_addr_i;
   logic [NUM_BIT-1:0] req_wdata_i;
   logic               rsp_valid_o;
   logic               rsp_ready_i;
   logic [NUM_BIT-1:0] rsp_rdata_o;
   logic               sram_ceb_o;
   logic               sram_web_o;
   logic [ADDR_W-1:0]  sram_a_o;
   logic [NUM_BIT-1:0] sram_d_o;
   logic [NUM_BIT-1:0] sram_q_i;

   int n_chk  = 0;
   int n_fail = 0;

   sram_req_ctrl #(
      .NUM_WORD (NUM_WORD),
      .NUM_BIT  (NUM_BIT),
      .ADDR_W   (ADDR_W),
      .RSP_DEPTH(3)
   ) dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .scan_en_i  (scan_en_i),
      .req_valid_i(req_valid_i),
      .req_ready_o(req_ready_o),
      .req_we_i   (req_we_i),
      .req_addr_i (req_addr_i),
      .req_wdata_i(req_wdata_i),
      .rsp_valid_o(rsp_valid_o),
      .rsp_ready_i(rsp_ready_i),
      .rsp_rdata_o(rsp_rdata_o),
      .sram_ceb_o (sram_ceb_o),
      .sram_web_o (sram_web_o),
      .sram_a_o   (sram_a_o),
      .sram_d_o   (sram_d_o),
      .sram_q_i   (sram_q_i)
   );

   always #5 clk_i = ~clk_i;

   // SRAM macro model: synchronous write, 1-cycle synchronous read
   logic [NUM_BIT-1:0] smem    [NUM_WORD];
   logic               written [NUM_WORD];

   always @(posedge clk_i) begin
      if (!sram_ceb_o) begin
         if (!sram_web_o) begin
            smem[sram_a_o]    <= sram_d_o;
            written[sram_a_o] <= 1'b1;
         end else begin
            sram_q_i <= (written[sram_a_o] === 1'b1) ? smem[sram_a_o] : 32'(sram_a_o);
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic drive(input logic v, input logic we, input logic [ADDR_W-1:0] a,
                        input logic [NUM_BIT-1:0] d);
      req_valid_i = v;
      req_we_i    = we;
      req_addr_i  = a;
      req_wdata_i = d;
   endtask

   initial begin
      sram_q_i    = '0;
      rst_i       = 1'b1;
      scan_en_i   = 1'b0;
      rsp_ready_i = 1'b0;
      drive(1'b0, 1'b0, '0, '0);

      // Reset state
      step();
      check("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
      check("rst_rsp_rdata", rsp_rdata_o, 32'd0);
      check("rst_ceb", 32'(sram_ceb_o), 32'd1);
      check("rst_web", 32'(sram_web_o), 32'd1);
      check("rst_ready", 32'(req_ready_o), 32'd1);
      step();
      rst_i = 1'b0;
      step();

      // Streaming: 8 back-to-back reads of 0..7, responses on consecutive cycles
      rsp_ready_i = 1'b1;
      for (int c = 0; c < 11; c++) begin
         if (c < 8) drive(1'b1, 1'b0, ADDR_W'(c), '0);
         else       drive(1'b0, 1'b0, '0, '0);
         #1;
         if (c < 8) check("stream_ready", 32'(req_ready_o), 32'd1);
         if (c >= 2 && c < 10) begin
            check("stream_valid", 32'(rsp_valid_o), 32'd1);
            check("stream_rdata", rsp_rdata_o, 32'(c - 2));
         end else begin
            check("stream_idle", 32'(rsp_valid_o), 32'd0);
         end
         step();
      end

      // Write then read of the same address on consecutive cycles
      rsp_ready_i = 1'b0;
      drive(1'b1, 1'b1, 11'h005, 32'hDEADBEEF);
      #1;
      check("wr_ceb", 32'(sram_ceb_o), 32'd0);
      check("wr_web", 32'(sram_web_o), 32'd0);
      check("wr_addr", 32'(sram_a_o), 32'h005);
      check("wr_data", sram_d_o, 32'hDEADBEEF);
      step();
      drive(1'b1, 1'b0, 11'h005, '0);
      #1;
      check("rd_ceb", 32'(sram_ceb_o), 32'd0);
      check("rd_web", 32'(sram_web_o), 32'd1);
      step();
      drive(1'b0, 1'b0, '0, '0);
      #1;
      check("raw_t1_valid", 32'(rsp_valid_o), 32'd0);
      check("idle_ceb", 32'(sram_ceb_o), 32'd1);
      step();
      check("raw_t2_valid", 32'(rsp_valid_o), 32'd1);
      check("raw_t2_rdata", rsp_rdata_o, 32'hDEADBEEF);
      step();
      check("raw_hold_valid", 32'(rsp_valid_o), 32'd1);
      check("raw_hold_rdata", rsp_rdata_o, 32'hDEADBEEF);
      rsp_ready_i = 1'b1;
      step();
      check("raw_drained", 32'(rsp_valid_o), 32'd0);

      // Backpressure: only 3 reads accepted, writes still flow, then drain
      rsp_ready_i = 1'b0;
      for (int c = 0; c < 11; c++) begin
         logic       exp_rdy;
         logic       exp_vld;
         logic [31:0] exp_dat;
         rsp_ready_i = (c >= 5);
         case (c)
            0:       drive(1'b1, 1'b0, 11'h010, '0);
            1:       drive(1'b1, 1'b0, 11'h011, '0);
            2:       drive(1'b1, 1'b0, 11'h012, '0);
            3, 5, 6: drive(1'b1, 1'b0, 11'h013, '0);
            4:       drive(1'b1, 1'b1, 11'h200, 32'hCAFE0001);
            7:       drive(1'b1, 1'b0, 11'h014, '0);
            default: drive(1'b0, 1'b0, '0, '0);
         endcase
         #1;
         exp_rdy = !(c == 3 || c == 5);
         exp_vld = (c >= 2 && c <= 9);
         case (c)
            2, 3, 4, 5: exp_dat = 32'h10;
            6:          exp_dat = 32'h11;
            7:          exp_dat = 32'h12;
            8:          exp_dat = 32'h13;
            default:    exp_dat = 32'h14;
         endcase
         if (c <= 7) check("bp_ready", 32'(req_ready_o), 32'(exp_rdy));
         if (c == 3 || c == 5) check("bp_ceb_blocked", 32'(sram_ceb_o), 32'd1);
         if (c == 4) check("bp_write_web", 32'(sram_web_o), 32'd0);
         check("bp_valid", 32'(rsp_valid_o), 32'(exp_vld));
         if (exp_vld) check("bp_rdata", rsp_rdata_o, exp_dat);
         step();
      end

      // Push/pop at count=2 with a read in flight, wrapping over 10 reads
      for (int c = 0; c < 14; c++) begin
         int k;
         k = (c <= 3) ? c : c - 1;
         rsp_ready_i = (c >= 3);
         if (c <= 10) drive(1'b1, 1'b0, ADDR_W'(32'h20 + k), '0);
         else         drive(1'b0, 1'b0, '0, '0);
         #1;
         if (c <= 10) check("wrap_ready", 32'(req_ready_o), (c == 3) ? 32'd0 : 32'd1);
         if (c >= 2 && c <= 12) begin
            check("wrap_valid", 32'(rsp_valid_o), 32'd1);
            check("wrap_rdata", rsp_rdata_o, (c == 2) ? 32'h20 : 32'(32'h20 + c - 3));
         end else begin
            check("wrap_idle", 32'(rsp_valid_o), 32'd0);
         end
         step();
      end

      // Scan: read issued just before scan still completes; FIFO poppable in scan
      for (int c = 0; c < 8; c++) begin
         scan_en_i   = (c >= 1 && c <= 3);
         rsp_ready_i = (c >= 3);
         if (c <= 4) drive(1'b1, 1'b0, (c == 0) ? 11'h030 : 11'h031, '0);
         else        drive(1'b0, 1'b0, '0, '0);
         #1;
         if (c >= 1 && c <= 3) begin
            check("scan_ready", 32'(req_ready_o), 32'd0);
            check("scan_ceb", 32'(sram_ceb_o), 32'd1);
         end
         if (c == 0 || c == 4) check("scan_fire_ceb", 32'(sram_ceb_o), 32'd0);
         if (c == 2 || c == 3) begin
            check("scan_valid", 32'(rsp_valid_o), 32'd1);
            check("scan_rdata", rsp_rdata_o, 32'h30);
         end else if (c == 6) begin
            check("post_scan_valid", 32'(rsp_valid_o), 32'd1);
            check("post_scan_rdata", rsp_rdata_o, 32'h31);
         end else begin
            check("scan_idle", 32'(rsp_valid_o), 32'd0);
         end
         step();
      end

      // Reset with 2 responses queued and 1 read in flight
      rsp_ready_i = 1'b0;
      for (int c = 0; c < 3; c++) begin
         drive(1'b1, 1'b0, ADDR_W'(32'h40 + c), '0);
         step();
      end
      drive(1'b0, 1'b0, '0, '0);
      #1;
      check("pre_rst_valid", 32'(rsp_valid_o), 32'd1);
      check("pre_rst_rdata", rsp_rdata_o, 32'h40);
      check("pre_rst_ready", 32'(req_ready_o), 32'd0);
      rst_i = 1'b1;
      #1;
      check("mid_rst_valid", 32'(rsp_valid_o), 32'd0);
      check("mid_rst_rdata", rsp_rdata_o, 32'd0);
      check("mid_rst_ready", 32'(req_ready_o), 32'd1);
      step();
      rst_i = 1'b0;
      step();
      check("post_rst_valid0", 32'(rsp_valid_o), 32'd0);
      step();
      check("post_rst_valid1", 32'(rsp_valid_o), 32'd0);
      rsp_ready_i = 1'b1;
      drive(1'b1, 1'b0, 11'h200, '0);
      #1;
      check("post_rst_ready", 32'(req_ready_o), 32'd1);
      step();
      drive(1'b0, 1'b0, '0, '0);
      #1;
      check("post_rst_t1", 32'(rsp_valid_o), 32'd0);
      step();
      check("post_rst_t2_valid", 32'(rsp_valid_o), 32'd1);
      check("post_rst_t2_rdata", rsp_rdata_o, 32'hCAFE0001);
      step();
      check("post_rst_empty", 32'(rsp_valid_o), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/sram_req_ctrl.md
Name: sram_req_ctrl

Overview:
Request-side controller that sits directly upstream of the single-port SRAM macro wrapper (active-low CEB/WEB, 1-cycle synchronous read). It converts a valid/ready request stream into SRAM pin activity. It captures read data into a small response FIFO, with credit-based backpressure so no read data is ever lost. During scan it blocks all accesses, because the macro clock is gated off while scan is enabled.

Parameters:
NUM_WORD, 2048, SRAM depth in words
NUM_BIT, 32, SRAM word width
ADDR_W, $clog2(NUM_WORD), address width
RSP_DEPTH, 3, response FIFO entries (>=2; 3 sustains 1 read/cycle)

Ports:
clk_i  in  1  clock, same clock that feeds the SRAM wrapper
rst_i  in  1  asynchronous active-high reset
scan_en_i  in  1  scan enable; 1 blocks all SRAM accesses
req_valid_i  in  1  request valid
req_ready_o  out  1  request accepted when valid&ready
req_we_i  in  1  1=write, 0=read
req_addr_i  in  ADDR_W  word address
req_wdata_i  in  NUM_BIT  write data
rsp_valid_o  out  1  read data valid
rsp_ready_i  in  1  consumer ready
rsp_rdata_o  out  NUM_BIT  read data (FIFO head)
sram_ceb_o  out  1  SRAM chip enable, active-low
sram_web_o  out  1  SRAM write enable, active-low
sram_a_o  out  ADDR_W  SRAM address
sram_d_o  out  NUM_BIT  SRAM write data
sram_q_i  in  NUM_BIT  SRAM read data, valid the cycle after a read

Behaviour:
- Reset (async, rst_i=1): FIFO empty, count=0, rd_inflight=0, rsp_valid_o=0, rsp_rdata_o=0. Combinational outputs: sram_ceb_o=1, req_ready_o per the rule below. An in-flight read is discarded. No response is produced for a read accepted in the cycle reset asserts.
- req_ready_o = ~scan_en_i & (req_we_i | (count + rd_inflight < RSP_DEPTH)).
  - Uses registered state only; no combinational path from rsp_ready_i.
  - Writes are never blocked by the FIFO.
- fire = req_valid_i & req_ready_o.
- SRAM drive, combinational in the fire cycle:
  - sram_ceb_o = ~fire
  - sram_web_o = ~(fire & req_we_i)
  - sram_a_o = req_addr_i
  - sram_d_o = req_wdata_i
  - When not fire: CEB=1, WEB=1, A/D pass through (don't care).
- rd_inflight register: set to 1 on a read fire, else 0.
- When rd_inflight=1, sram_q_i is pushed into the FIFO at that clock edge. The response becomes visible (rsp_valid_o=1) in the next cycle. Read latency is therefore fire cycle t -> rsp_valid_o at t+2.
- Writes: one cycle, no response, no FIFO effect.
- FIFO:
  - Circular buffer of RSP_DEPTH entries; rd/wr pointers wrap at RSP_DEPTH (non-power-of-2 allowed).
  - Pop when rsp_valid_o & rsp_ready_i.
  - Push and pop in the same cycle: count unchanged, order preserved.
  - The credit rule guarantees a push never meets a full FIFO. A push at full is an assertion failure.
- Responses are returned in issue order. rsp_rdata_o is held stable while rsp_valid_o=1 and rsp_ready_i=0.
- Read-after-write to the same address on consecutive cycles returns the new data (SRAM is sequential; no hazard logic).
- scan_en_i=1: req_ready_o=0 and sram_ceb_o=1.
  - A read issued the cycle before scan_en_i rises still completes and is pushed.
  - FIFO contents are kept and can still be popped.
- Throughput: with RSP_DEPTH=3 and rsp_ready_i held high, 1 read per cycle sustained. With RSP_DEPTH=2, 1 read per 2 cycles.

Test Plan:
- Write then read: write 0xDEADBEEF @0x005 (CEB=0, WEB=0 same cycle); read @0x005 next cycle -> rsp_valid_o=1 exactly 2 cycles after the read fire, rsp_rdata_o=0xDEADBEEF.
- Streaming reads: 8 back-to-back reads of addresses 0..7 (preloaded with value = addr), rsp_ready_i=1 -> req_ready_o never drops, 8 in-order responses 0..7 on consecutive cycles.
- Backpressure: rsp_ready_i=0, issue 5 reads -> exactly 3 accepted, then req_ready_o=0 for reads. Writes are still accepted meanwhile. Raise rsp_ready_i -> data drains in order and the 2 pending reads are then accepted.
- Simultaneous push/pop at count=2 with an in-flight read -> count stays 2, no overflow, no data loss; FIFO wrap-around is exercised over 10 reads.
- Scan: assert scan_en_i while req_valid_i=1 -> sram_ceb_o=1 and req_ready_o=0 for the whole scan window. A read issued one cycle earlier still returns its data.
- Reset mid-operation: assert rst_i with 2 responses queued and 1 read in flight -> rsp_valid_o=0 immediately. After release, the first new read returns correct data with no stale entries.
